// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit: mode encodings,
// default store size and the load/fetch state machine encoding.
package inst_fetch_unit_pkg;

    localparam int INST_SIZE = 8;

    localparam logic [2:0] MODE_STALL = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_EXEC  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_load_lat_tracker.sv
// Carries each issued BRAM address alongside a valid bit through an RD_LAT-deep
// pipe so the returning read data can be matched to its store index.
module load_lat_tracker #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic              ret_valid_o,
    output logic [ADDR_W-1:0] ret_addr_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Address stages need no reset: they are only consumed when the valid bit is set.
    always_ff @(posedge clk) begin
        addr_q[0] <= issue_addr_i;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign ret_valid_o = vld_q[RD_LAT-1];
    assign ret_addr_o  = addr_q[RD_LAT-1];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction store with a BRAM copy-in engine (LOAD) and a registered
// FETCH_W-wide fetch port (EXEC); reloadable from DONE without a reset.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W     = INST_SIZE,
    parameter int LOAD_WORDS = 2**ADDR_W,
    parameter int RD_LAT     = 2,
    parameter int FETCH_W    = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [2:0]             mode_i,
    input  logic                   reload_i,
    output logic                   bram_en_o,
    output logic [ADDR_W-1:0]      bram_addr_o,
    input  logic [31:0]            bram_dout_i,
    output logic                   done_o,
    input  logic                   fetch_req_i,
    input  logic [31:0]            fetch_pc_i,
    output logic                   inst_valid_o,
    output logic [32*FETCH_W-1:0]  inst_o,
    output logic                   inst_fault_o
);

    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LOAD_WORDS - 1);

    fetch_state_t      state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic              bram_en_q, bram_en_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;

    logic              ret_valid;
    logic [ADDR_W-1:0] ret_addr;

    logic [31:0]       store_q [2**ADDR_W];

    logic                  inst_valid_q;
    logic                  inst_fault_q;
    logic [32*FETCH_W-1:0] inst_q;
    logic [32*FETCH_W-1:0] rd_data;
    logic [ADDR_W-1:0]     idx;
    logic                  accept;
    logic                  unused_pc;

    // The registered BRAM strobe is the moment a read is actually presented.
    load_lat_tracker #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .issue_i      (bram_en_q),
        .issue_addr_i (bram_addr_q),
        .ret_valid_o  (ret_valid),
        .ret_addr_o   (ret_addr)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        if (ret_valid) begin
            ret_cnt_d = ret_cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (mode_i == MODE_LOAD) begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = '0;
                    issue_cnt_d = CNT_W'(1);
                    ret_cnt_d   = '0;
                    state_d     = (LAST == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                // Any mode other than LOAD pauses issue with the address held.
                if (mode_i == MODE_LOAD) begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = issue_cnt_q[ADDR_W-1:0];
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ret_valid && (ret_cnt_q == LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (reload_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes are suppressed during reset so in-flight reads are discarded.
    always_ff @(posedge clk) begin
        if (rstn && ret_valid) begin
            store_q[ret_addr] <= bram_dout_i;
        end
    end

    assign idx       = fetch_pc_i[ADDR_W+1:2];
    assign unused_pc = ^fetch_pc_i[31:ADDR_W+2];

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_W; gi++) begin : g_rd
            logic [ADDR_W-1:0] slot_idx;
            assign slot_idx             = idx + ADDR_W'(gi);
            assign rd_data[32*gi +: 32] = store_q[slot_idx];
        end
    endgenerate

    assign accept = fetch_req_i && (mode_i == MODE_EXEC) && (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            inst_valid_q <= 1'b0;
            inst_fault_q <= 1'b0;
            inst_q       <= '0;
        end else begin
            inst_valid_q <= accept;
            inst_fault_q <= accept && (fetch_pc_i[1:0] != 2'b00);
            if (accept) begin
                inst_q <= rd_data;
            end
        end
    end

    assign bram_en_o    = bram_en_q;
    assign bram_addr_o  = bram_addr_q;
    assign done_o       = (state_q == DONE);
    assign inst_valid_o = inst_valid_q;
    assign inst_fault_o = inst_fault_q;
    assign inst_o       = inst_q;

endmodule
